// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronizes the PLL lock, waits for a stability window,
// then releases per-domain resets one at a time and raises ready.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | holding every reset, waiting for the synchronized lock
// STABLE    | lock seen; counting the stability window, resets still held
// RELEASE   | releasing domains in index order, one every STAGGER cycles
// RUN       | every domain released, ready high
module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int NUM_DOMAINS   = 3,
    parameter int STAGGER       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   locked_async,
    input  logic                   soft_reset,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic [7:0]             lock_loss_cnt,
    output logic [1:0]             state_dbg
);

    // One counter serves both the stability window and the stagger gap.
    localparam int CNT_MAX = (STABLE_CYCLES > STAGGER) ? STABLE_CYCLES : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic [7:0]             loss_q, loss_d;
    logic                   locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous lock through the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], locked_async};
    end

    // Next-state and output logic; lock loss outranks soft reset, which outranks counting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = 1'b0;
        loss_d    = loss_q;

        case (state_q)
            WAIT_LOCK: begin
                rst_out_d = '1;
                cnt_d     = '0;
                idx_d     = '0;
                if (locked_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                rst_out_d = '1;
                idx_d     = '0;
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (soft_reset) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (!locked_s) begin
                    state_d   = WAIT_LOCK;
                    rst_out_d = '1;
                    cnt_d     = '0;
                    idx_d     = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else if (soft_reset) begin
                    state_d   = STABLE;
                    rst_out_d = '1;
                    cnt_d     = '0;
                    idx_d     = '0;
                end else if (state_q == RUN) begin
                    ready_d = 1'b1;
                end else if (cnt_q == STAGGER_LAST) begin
                    // Only a single bit ever drops, always the next in index order.
                    rst_out_d[idx_q] = 1'b0;
                    cnt_d            = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = WAIT_LOCK;
                rst_out_d = '1;
                cnt_d     = '0;
                idx_d     = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            sync_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            loss_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            loss_q    <= loss_d;
        end
    end

    assign rst_out       = rst_out_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;
    assign state_dbg     = state_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumer-side companion to the core PLL wrapper: takes the PLL's asynchronous `locked` output and produces staggered, per-domain synchronous resets plus a `ready` flag.
- Qualifies lock with a stability window. Re-asserts all resets on lock loss or soft reset. Counts lock-loss events for the OSD/debug path.
- Runs on one PLL output clock (the system clock) and sits between the PLL wrapper and the core top level.

Parameters:
- SYNC_STAGES, 2: synchronizer flop depth for `locked_async`; minimum 2.
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release; minimum 2.
- NUM_DOMAINS, 3: number of reset outputs, released in index order 0..N-1.
- STAGGER, 16: cycles between successive domain releases; minimum 1.

Ports:
- clk, input, 1: system clock (PLL output).
- rst_n, input, 1: asynchronous active-low reset.
- locked_async, input, 1: PLL lock; asynchronous to clk.
- soft_reset, input, 1: synchronous active-high re-sequence request (OSD/user reset).
- rst_out, output, NUM_DOMAINS: active-high synchronous resets, one per domain.
- ready, output, 1: high once every domain is released.
- lock_loss_cnt, output, 8: saturating count of lock losses after release began.
- state_dbg, output, 2: current FSM state encoding.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchronizer flops = 0; state = WAIT_LOCK.
  - rst_out = all ones; ready = 0; lock_loss_cnt = 0; internal counters = 0.
  - All outputs are registered.
- Synchronizer: `locked_s` is the last of SYNC_STAGES flops clocked by clk. Only `locked_s` is used by the FSM.
- State encoding: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3.
- WAIT_LOCK:
  - rst_out all ones, ready = 0.
  - locked_s=1 moves to STABLE with cnt=0. soft_reset is ignored in this state.
- STABLE:
  - cnt increments each cycle while locked_s=1.
  - locked_s=0 moves to WAIT_LOCK; no loss count.
  - soft_reset=1 holds cnt at 0.
  - Leave on the edge where cnt==STABLE_CYCLES-1 and locked_s=1: go to RELEASE with cnt=0, idx=0.
- RELEASE:
  - cnt counts 0..STAGGER-1.
  - On the edge where cnt==STAGGER-1: clear rst_out[idx], increment idx, reset cnt to 0.
  - When idx reaches NUM_DOMAINS-1 and that domain is released, move to RUN.
- RUN:
  - ready = 1 (registered). It rises one cycle after rst_out[NUM_DOMAINS-1] falls.
- Timing (edge E = transition into STABLE):
  - rst_out[k] falls at edge E+STABLE_CYCLES+(k+1)*STAGGER.
  - ready rises one edge after the last release.
- Lock loss (locked_s=0) in RELEASE or RUN:
  - Next edge: state = WAIT_LOCK, rst_out = all ones, ready = 0, cnt/idx = 0.
  - lock_loss_cnt increments, saturating at 255.
- soft_reset=1 in RELEASE or RUN (with locked_s=1):
  - Next edge: state = STABLE with cnt=0, rst_out = all ones, ready = 0.
  - No loss count. Lock qualification restarts from zero.
- Priority when events coincide: rst_n > lock loss > soft_reset > normal count/advance. Lock loss and soft_reset on the same edge are treated as lock loss and counted.
- Glitch-free rule: rst_out bits only go 1→0 in index order. Any 0→1 transition sets all bits simultaneously; there is no partial re-assert.
- Counter width: cnt is wide enough for max(STABLE_CYCLES, STAGGER)-1. It never wraps, because transitions occur at terminal count.
- lock_loss_cnt is cleared only by rst_n.

Test Plan:
Bench parameters: SYNC_STAGES=2, STABLE_CYCLES=8, STAGGER=4, NUM_DOMAINS=3.
1. rst_n low, then release with locked_async=0 for 50 cycles → rst_out=3'b111, ready=0, state_dbg=0, lock_loss_cnt=0 throughout.
2. locked_async rises and holds → STABLE entered 2–3 edges later (E). rst_out[0] falls at E+12, rst_out[1] at E+16, rst_out[2] at E+20. ready rises at E+21. state_dbg=3.
3. In STABLE at cnt=5, drop locked_async for 3 cycles, then restore → returns to WAIT_LOCK, re-qualifies a full 8 cycles, lock_loss_cnt stays 0.
4. In RUN, drop locked_async → within SYNC_STAGES+1 edges rst_out=3'b111 and ready=0, lock_loss_cnt=1. Relock → full sequence repeats. Repeat 300 losses → lock_loss_cnt saturates at 255.
5. In RELEASE after rst_out[0] has fallen, pulse soft_reset for 1 cycle → next edge rst_out=3'b111, state_dbg=1, cnt=0. Release reoccurs 12/16/20 cycles after the pulse edge. lock_loss_cnt unchanged.
6. Assert rst_n mid-RUN asynchronously (between edges) → outputs return to reset values immediately without waiting for an edge. lock_loss_cnt=0.
